// File: rtl/shift_sel_unpacker.sv
// shift_sel_unpacker: receive-side inverse of the byte-swap / left-shift packer.
// Restores byte order on accept, then undoes the packer's left shift with an
// iterative right shift (one bit per cycle) before presenting the word downstream.
`timescale 1ns/1ps

module shift_sel_unpacker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word,
  input  logic [3:0]       in_shift_amount,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_word,
  output logic [15:0]      out_mask,
  output logic [3:0]       out_shift_amount,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      shiftReg_q;
  logic [3:0]       cnt_q;
  logic             arith_q;
  logic             outValid_q;
  logic [15:0]      outWord_q;
  logic [15:0]      outMask_q;
  logic [3:0]       outShiftAmount_q;
  logic [CNT_W-1:0] outCount_q;

  logic [15:0]      swapped_d;
  logic [15:0]      shifted_d;

  // Byte-swap of the incoming word and one-bit right shift of the working register.
  always_comb begin
    swapped_d = {in_word[7:0], in_word[15:8]};
    shifted_d = {(arith_q ? shiftReg_q[15] : 1'b0), shiftReg_q[15:1]};
  end

  // Ready is qualified by reset so it only rises once reset is released.
  assign in_ready         = rst_n && (state_q == IDLE);
  assign out_valid        = outValid_q;
  assign out_word         = outWord_q;
  assign out_mask         = outMask_q;
  assign out_shift_amount = outShiftAmount_q;
  assign out_count        = outCount_q;

  // Control FSM with registered outputs; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      shiftReg_q       <= 16'h0000;
      cnt_q            <= 4'd0;
      arith_q          <= 1'b0;
      outValid_q       <= 1'b0;
      outWord_q        <= 16'h0000;
      outMask_q        <= 16'h0000;
      outShiftAmount_q <= 4'd0;
      outCount_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shiftReg_q       <= swapped_d;
            cnt_q            <= in_shift_amount;
            arith_q          <= in_arith;
            outShiftAmount_q <= in_shift_amount;
            outMask_q        <= 16'hFFFF >> in_shift_amount;
            if (in_shift_amount == 4'd0) begin
              state_q    <= DONE;
              outValid_q <= 1'b1;
              outWord_q  <= swapped_d;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shiftReg_q <= shifted_d;
          cnt_q      <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            outWord_q  <= shifted_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            outCount_q <= outCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sel_unpacker.sv
// Directed self-checking bench for shift_sel_unpacker.
`timescale 1ns/1ps

module tb_shift_sel_unpacker;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_word;
  logic [3:0]       in_shift_amount;
  logic             in_arith;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_word;
  logic [15:0]      out_mask;
  logic [3:0]       out_shift_amount;
  logic [CNT_W-1:0] out_count;

  int nChecks = 0;
  int nFails  = 0;

  shift_sel_unpacker #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word(in_word),
    .in_shift_amount(in_shift_amount),
    .in_arith(in_arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_mask(out_mask),
    .out_shift_amount(out_shift_amount),
    .out_count(out_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one word and wait (bounded) for the accept edge; inputs are scrambled afterwards.
  task automatic applyStimulus(input logic [15:0] w, input logic [3:0] a, input logic ar);
    int t;
    t = 0;
    @(negedge clk);
    in_word = w;
    in_shift_amount = a;
    in_arith = ar;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    nChecks++;
    if (!in_ready) begin
      nFails++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_word = 16'hDEAD;
      in_shift_amount = 4'hA;
      in_arith = ~ar;
    end
  endtask

  // Count falling edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_word = 16'h0;
    in_shift_amount = 4'd0;
    in_arith = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0 || out_word !== 16'h0 || out_mask !== 16'h0 ||
        out_shift_amount !== 4'd0 || out_count !== 8'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: valid=%0b word=%h mask=%h amt=%0d cnt=%0d required all zero",
               out_valid, out_word, out_mask, out_shift_amount, out_count);
    end
    rst_n = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_amt0();
    int lat;
    out_ready = 1'b1;
    applyStimulus(16'h3412, 4'd0, 1'b0);
    waitValid(lat);
    nChecks++;
    if (lat !== 1) begin
      nFails++;
      $display("[TB] FAIL amt0_latency: got %0d required 1", lat);
    end
    nChecks++;
    if (out_word !== 16'h1234 || out_mask !== 16'hFFFF) begin
      nFails++;
      $display("[TB] FAIL amt0_word: word=%h mask=%h required 1234/FFFF", out_word, out_mask);
    end
    @(posedge clk);
    #1;
    nChecks++;
    if (out_count !== 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL amt0_handshake: cnt=%0d valid=%0b ready=%0b required 1/0/1",
               out_count, out_valid, in_ready);
    end
  endtask

  task automatic test_logical_shift();
    int lat;
    applyStimulus(16'h00FF, 4'd4, 1'b0);
    waitValid(lat);
    nChecks++;
    if (lat !== 5) begin
      nFails++;
      $display("[TB] FAIL logic4_latency: got %0d required 5", lat);
    end
    nChecks++;
    if (out_word !== 16'h0FF0 || out_mask !== 16'h0FFF || out_shift_amount !== 4'd4) begin
      nFails++;
      $display("[TB] FAIL logic4_word: word=%h mask=%h amt=%0d required 0FF0/0FFF/4",
               out_word, out_mask, out_shift_amount);
    end
    @(posedge clk);
  endtask

  task automatic test_arith_shift();
    int lat;
    applyStimulus(16'h00FF, 4'd4, 1'b1);
    waitValid(lat);
    nChecks++;
    if (lat !== 5 || out_word !== 16'hFFF0 || out_mask !== 16'h0FFF) begin
      nFails++;
      $display("[TB] FAIL arith4: lat=%0d word=%h mask=%h required 5/FFF0/0FFF",
               lat, out_word, out_mask);
    end
    @(posedge clk);
    applyStimulus(16'h00FF, 4'd15, 1'b1);
    waitValid(lat);
    nChecks++;
    if (lat !== 16) begin
      nFails++;
      $display("[TB] FAIL arith15_latency: got %0d required 16", lat);
    end
    nChecks++;
    if (out_word !== 16'hFFFF || out_mask !== 16'h0001 || out_shift_amount !== 4'd15) begin
      nFails++;
      $display("[TB] FAIL arith15_word: word=%h mask=%h amt=%0d required FFFF/0001/15",
               out_word, out_mask, out_shift_amount);
    end
    @(posedge clk);
    applyStimulus(16'h00FF, 4'd15, 1'b0);
    waitValid(lat);
    nChecks++;
    if (out_word !== 16'h0001 || out_mask !== 16'h0001) begin
      nFails++;
      $display("[TB] FAIL logic15_word: word=%h mask=%h required 0001/0001", out_word, out_mask);
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int holdErrs;
    logic [CNT_W-1:0] cntBefore;
    #1;
    cntBefore = out_count;
    out_ready = 1'b0;
    applyStimulus(16'hABCD, 4'd2, 1'b0);
    waitValid(lat);
    holdErrs = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_word = 16'h1111 * i[15:0];
      in_shift_amount = 4'd0;
      if (out_valid !== 1'b1 || out_word !== 16'h336A || out_mask !== 16'h3FFF ||
          out_shift_amount !== 4'd2 || in_ready !== 1'b0 || out_count !== cntBefore)
        holdErrs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    nChecks++;
    if (holdErrs !== 0) begin
      nFails++;
      $display("[TB] FAIL backpressure_hold: %0d bad cycles, word=%h required 336A held, 0 bad cycles",
               holdErrs, out_word);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    nChecks++;
    if (out_count !== cntBefore + 8'd1 || out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL backpressure_release: cnt=%0d valid=%0b required %0d/0",
               out_count, out_valid, cntBefore + 8'd1);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    out_ready = 1'b1;
    applyStimulus(16'h1234, 4'd8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || out_word !== 16'h0 || out_mask !== 16'h0 ||
        out_shift_amount !== 4'd0 || out_count !== 8'd0) begin
      nFails++;
      $display("[TB] FAIL midreset_outputs: valid=%0b word=%h mask=%h amt=%0d cnt=%0d required all zero",
               out_valid, out_word, out_mask, out_shift_amount, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h3412, 4'd0, 1'b0);
    waitValid(lat);
    nChecks++;
    if (lat !== 1 || out_word !== 16'h1234) begin
      nFails++;
      $display("[TB] FAIL midreset_next_word: lat=%0d word=%h required 1/1234", lat, out_word);
    end
    @(posedge clk);
    #1;
    nChecks++;
    if (out_count !== 8'd1) begin
      nFails++;
      $display("[TB] FAIL midreset_count: got %0d required 1", out_count);
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    int delivered;
    int wordErrs;
    int runErrs;
    int cycles;
    logic prevReady;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_word = 16'h3412;
    in_shift_amount = 4'd1;
    in_arith = 1'b0;
    accepted = 0;
    delivered = 0;
    wordErrs = 0;
    runErrs = 0;
    cycles = 0;
    prevReady = 1'b0;
    while (delivered < 257 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (out_valid) begin
        delivered++;
        if (out_word !== 16'h091A) wordErrs++;
      end
      if (in_ready && prevReady) runErrs++;
      prevReady = in_ready;
      in_valid = (accepted < 257);
      if (in_ready && in_valid) accepted++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    nChecks++;
    if (delivered !== 257) begin
      nFails++;
      $display("[TB] FAIL b2b_delivered: got %0d required 257", delivered);
    end
    nChecks++;
    if (wordErrs !== 0) begin
      nFails++;
      $display("[TB] FAIL b2b_words: %0d bad words required 0 (expected 091A)", wordErrs);
    end
    nChecks++;
    if (runErrs !== 0) begin
      nFails++;
      $display("[TB] FAIL b2b_ready_gap: %0d multi-cycle ready gaps required 0", runErrs);
    end
    nChecks++;
    if (out_count !== 8'd1) begin
      nFails++;
      $display("[TB] FAIL b2b_count_wrap: got %0d required 1", out_count);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_amt0();
    test_logical_shift();
    test_arith_shift();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
